// File: rtl/fp_serial_minmax.sv
// Byte-serial IEEE-754 min/max/compare/negate/abs unit: operands stream in LSB-first,
// the result streams out LSB-first with done high. W = 1+EXP_W+MAN_W must be a multiple of 8.
module fp_serial_minmax #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] in,
  input  logic [2:0] opcode,
  input  logic       start,
  output logic [7:0] out,
  output logic       done,
  output logic [3:0] state_out
);

  localparam int W  = 1 + EXP_W + MAN_W;
  localparam int NB = W / 8;
  localparam int CW = (NB > 1) ? $clog2(NB) : 1;

  localparam logic [2:0] OP_MIN = 3'b000;
  localparam logic [2:0] OP_MAX = 3'b001;
  localparam logic [2:0] OP_CMP = 3'b010;
  localparam logic [2:0] OP_NEG = 3'b011;
  localparam logic [2:0] OP_ABS = 3'b100;

  typedef enum logic [3:0] {
    IDLE   = 4'd0,
    LOAD_A = 4'd1,
    LOAD_B = 4'd2,
    EXEC   = 4'd3,
    OUTPUT = 4'd4
  } state_t;

  state_t         state_q;
  logic [CW-1:0]  cnt_q;
  logic [2:0]     op_q;
  logic [W-1:0]   a_q, b_q, res_q;
  logic [7:0]     out_q;
  logic           done_q;

  logic [CW-1:0]  cnt_nx;
  logic           cnt_last;
  logic           unary;
  logic           nan_a, nan_b, any_nan;
  logic [W-1:0]   key_a, key_b;
  logic           eq, lt, key_lt;
  logic [W-1:0]   qnan;
  logic [W-1:0]   res_d;

  assign cnt_nx   = cnt_q + 1'b1;
  assign cnt_last = (cnt_q == CW'(NB - 1));
  assign unary    = (op_q == OP_NEG) || (op_q == OP_ABS);

  assign nan_a   = (&a_q[W-2:MAN_W]) && (|a_q[MAN_W-1:0]);
  assign nan_b   = (&b_q[W-2:MAN_W]) && (|b_q[MAN_W-1:0]);
  assign any_nan = nan_a || nan_b;
  assign qnan    = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

  // Sign-magnitude mapped to an unsigned total order: negatives inverted, positives
  // offset by the top bit, so -0 sorts just below +0.
  assign key_a  = a_q[W-1] ? ~a_q : {1'b1, a_q[W-2:0]};
  assign key_b  = b_q[W-1] ? ~b_q : {1'b1, b_q[W-2:0]};
  assign key_lt = key_a < key_b;
  assign eq     = (a_q == b_q) || ((a_q[W-2:0] == '0) && (b_q[W-2:0] == '0));
  assign lt     = !eq && key_lt;

  always_comb begin
    res_d = '0;
    case (op_q)
      OP_MIN:  res_d = any_nan ? qnan : (key_lt ? a_q : b_q);
      OP_MAX:  res_d = any_nan ? qnan : (key_lt ? b_q : a_q);
      OP_CMP:  res_d[3:0] = any_nan ? 4'b1000 : {1'b0, !eq && !lt, eq, lt};
      OP_NEG:  res_d = {~a_q[W-1], a_q[W-2:0]};
      OP_ABS:  res_d = {1'b0, a_q[W-2:0]};
      default: res_d = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      out_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          cnt_q  <= '0;
          out_q  <= '0;
          done_q <= 1'b0;
          if (start) begin
            op_q    <= opcode;
            state_q <= LOAD_A;
          end
        end
        LOAD_A: begin
          a_q[{cnt_q, 3'b000} +: 8] <= in;
          if (cnt_last) begin
            cnt_q   <= '0;
            state_q <= unary ? EXEC : LOAD_B;
          end else begin
            cnt_q <= cnt_nx;
          end
        end
        LOAD_B: begin
          b_q[{cnt_q, 3'b000} +: 8] <= in;
          if (cnt_last) begin
            cnt_q   <= '0;
            state_q <= EXEC;
          end else begin
            cnt_q <= cnt_nx;
          end
        end
        EXEC: begin
          // Byte 0 is presented alongside the state change so done aligns with OUTPUT.
          res_q   <= res_d;
          out_q   <= res_d[7:0];
          done_q  <= 1'b1;
          cnt_q   <= '0;
          state_q <= OUTPUT;
        end
        OUTPUT: begin
          if (cnt_last) begin
            cnt_q   <= '0;
            out_q   <= '0;
            done_q  <= 1'b0;
            state_q <= IDLE;
          end else begin
            cnt_q <= cnt_nx;
            out_q <= res_q[{cnt_nx, 3'b000} +: 8];
          end
        end
        default: begin
          cnt_q   <= '0;
          out_q   <= '0;
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign out       = out_q;
  assign done      = done_q;
  assign state_out = state_q;

endmodule

// File: tb/tb_fp_serial_minmax.sv
// Directed bench for fp_serial_minmax: FP32 and 16-bit (EXP_W=5, MAN_W=10) instances.
module tb_fp_serial_minmax;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] in = '0;
  logic [2:0] opcode = '0;
  logic       start32 = 1'b0, start16 = 1'b0;
  logic [7:0] out32, out16;
  logic       done32, done16;
  logic [3:0] st32, st16;

  logic       hsel = 1'b0;
  logic [7:0] mout;
  logic       mdone;
  logic [3:0] mst;

  int vectors = 0;
  int errors  = 0;

  always #5 clk = ~clk;

  fp_serial_minmax #(.EXP_W(8), .MAN_W(23)) dut32 (
    .clk(clk), .rst_n(rst_n), .in(in), .opcode(opcode), .start(start32),
    .out(out32), .done(done32), .state_out(st32)
  );

  fp_serial_minmax #(.EXP_W(5), .MAN_W(10)) dut16 (
    .clk(clk), .rst_n(rst_n), .in(in), .opcode(opcode), .start(start16),
    .out(out16), .done(done16), .state_out(st16)
  );

  assign mout  = hsel ? out16 : out32;
  assign mdone = hsel ? done16 : done32;
  assign mst   = hsel ? st16 : st32;

  // Runs one transaction; inputs change and outputs are sampled on falling edges.
  // lat counts rising edges from the start edge (counted as 1) to the first done cycle.
  task automatic xact(input bit h, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                      input bit hold_start, input bit rel_rst,
                      output logic [31:0] got, output int lat, output int ndone,
                      output bit saw2, output bit tail_ok);
    int nb;
    bit binary;
    nb     = h ? 2 : 4;
    binary = !(op == 3'b011 || op == 3'b100);
    saw2   = 1'b0;
    got    = '0;
    ndone  = 0;
    @(negedge clk);
    hsel   = h;
    opcode = op;
    in     = '0;
    if (h) start16 = 1'b1; else start32 = 1'b1;
    if (rel_rst) rst_n = 1'b1;
    @(negedge clk);
    lat = 1;
    start16 = 1'b0;
    start32 = 1'b0;
    for (int i = 0; i < nb; i++) begin
      in = a[8*i +: 8];
      @(negedge clk);
      lat++;
      if (mst == 4'd2) saw2 = 1'b1;
    end
    if (binary) begin
      for (int i = 0; i < nb; i++) begin
        in = b[8*i +: 8];
        @(negedge clk);
        lat++;
        if (mst == 4'd2) saw2 = 1'b1;
      end
    end
    in = '0;
    while (!mdone && lat < 64) begin
      @(negedge clk);
      lat++;
      if (mst == 4'd2) saw2 = 1'b1;
    end
    for (int k = 0; k < nb; k++) begin
      if (mdone) ndone++;
      got[8*k +: 8] = mout;
      if (hold_start) begin
        if (h) start16 = 1'b1; else start32 = 1'b1;
      end
      @(negedge clk);
    end
    start16 = 1'b0;
    start32 = 1'b0;
    tail_ok = (mdone === 1'b0) && (mout === 8'h00) && (mst === 4'd0);
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    vectors++;
    if (st32 !== 4'd0 || st16 !== 4'd0) begin
      errors++; $display("FAIL reset_state: got %0d/%0d want 0/0", st32, st16);
    end
    vectors++;
    if (out32 !== 8'h00 || out16 !== 8'h00) begin
      errors++; $display("FAIL reset_out: got %h/%h want 00/00", out32, out16);
    end
    vectors++;
    if (done32 !== 1'b0 || done16 !== 1'b0) begin
      errors++; $display("FAIL reset_done: got %b/%b want 0/0", done32, done16);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_vectors;
    logic [2:0]  op [17];
    logic [31:0] a  [17];
    logic [31:0] b  [17];
    logic [31:0] r  [17];
    logic [31:0] got;
    int lat, nd, exp_lat;
    bit saw2, tail, bin;
    op = '{3'd1, 3'd0, 3'd1, 3'd1, 3'd0, 3'd0, 3'd1,
           3'd2, 3'd2, 3'd2, 3'd2, 3'd2, 3'd5, 3'd7,
           3'd3, 3'd4, 3'd3};
    a  = '{32'h3F800000, 32'h00000000, 32'h00000000, 32'h7FC00001, 32'h3F800000, 32'hC0000000, 32'h7F800000,
           32'h00000000, 32'h7FC00001, 32'hC0000000, 32'h3F800000, 32'h7F800000, 32'h3F800000, 32'hFFFFFFFF,
           32'h3F800000, 32'hFFC00123, 32'h80000000};
    b  = '{32'hC0000000, 32'h80000000, 32'h80000000, 32'h3F800000, 32'h7F800001, 32'hBF800000, 32'h7F7FFFFF,
           32'h80000000, 32'h3F800000, 32'h3F800000, 32'hC0000000, 32'h7F800000, 32'h40000000, 32'h00000001,
           32'h0, 32'h0, 32'h0};
    r  = '{32'h3F800000, 32'h80000000, 32'h00000000, 32'h7FC00000, 32'h7FC00000, 32'hC0000000, 32'h7F800000,
           32'h00000002, 32'h00000008, 32'h00000001, 32'h00000004, 32'h00000002, 32'h00000000, 32'h00000000,
           32'hBF800000, 32'h7FC00123, 32'h00000000};
    for (int i = 0; i < 17; i++) begin
      bin     = !(op[i] == 3'd3 || op[i] == 3'd4);
      exp_lat = bin ? 10 : 6;
      xact(1'b0, op[i], a[i], b[i], 1'b0, 1'b0, got, lat, nd, saw2, tail);
      vectors++;
      if (got !== r[i]) begin
        errors++; $display("FAIL vec%0d_result: got %h want %h", i, got, r[i]);
      end
      vectors++;
      if (lat != exp_lat) begin
        errors++; $display("FAIL vec%0d_latency: got %0d want %0d", i, lat, exp_lat);
      end
      vectors++;
      if (nd != 4) begin
        errors++; $display("FAIL vec%0d_done_cycles: got %0d want 4", i, nd);
      end
      vectors++;
      if (saw2 != bin) begin
        errors++; $display("FAIL vec%0d_load_b_seen: got %0d want %0d", i, saw2, bin);
      end
      vectors++;
      if (!tail) begin
        errors++; $display("FAIL vec%0d_idle_after: got st=%0d out=%h done=%b want 0/00/0", i, st32, out32, done32);
      end
    end
  endtask

  task automatic test_reset_mid_load;
    logic [31:0] a, b, got;
    int lat, nd;
    bit saw2, tail;
    a = 32'h12345678;
    b = 32'h9ABCDEF0;
    hsel = 1'b0;
    @(negedge clk);
    opcode = 3'd1; start32 = 1'b1;
    @(negedge clk);
    start32 = 1'b0;
    for (int i = 0; i < 4; i++) begin in = a[8*i +: 8]; @(negedge clk); end
    for (int i = 0; i < 2; i++) begin in = b[8*i +: 8]; @(negedge clk); end
    in = b[23:16];
    rst_n = 1'b0;
    @(negedge clk);
    vectors++;
    if (st32 !== 4'd0 || out32 !== 8'h00 || done32 !== 1'b0) begin
      errors++; $display("FAIL reset_in_load_b: got st=%0d out=%h done=%b want 0/00/0", st32, out32, done32);
    end
    xact(1'b0, 3'd1, 32'h40000000, 32'h3F800000, 1'b0, 1'b1, got, lat, nd, saw2, tail);
    vectors++;
    if (got !== 32'h40000000) begin
      errors++; $display("FAIL post_reset_max: got %h want 40000000", got);
    end
    vectors++;
    if (lat != 10) begin
      errors++; $display("FAIL post_reset_latency: got %0d want 10", lat);
    end
  endtask

  task automatic test_reset_mid_output;
    logic [31:0] a;
    a = 32'h3F800001;
    hsel = 1'b0;
    @(negedge clk);
    opcode = 3'd3; start32 = 1'b1;
    @(negedge clk);
    start32 = 1'b0;
    for (int i = 0; i < 4; i++) begin in = a[8*i +: 8]; @(negedge clk); end
    in = '0;
    @(negedge clk);
    vectors++;
    if (done32 !== 1'b1 || out32 !== 8'h01 || st32 !== 4'd4) begin
      errors++; $display("FAIL output_first_byte: got done=%b out=%h st=%0d want 1/01/4", done32, out32, st32);
    end
    rst_n = 1'b0;
    @(negedge clk);
    vectors++;
    if (st32 !== 4'd0 || out32 !== 8'h00 || done32 !== 1'b0) begin
      errors++; $display("FAIL reset_in_output: got st=%0d out=%h done=%b want 0/00/0", st32, out32, done32);
    end
    rst_n = 1'b1;
    @(negedge clk);
    vectors++;
    if (out32 !== 8'h00 || done32 !== 1'b0) begin
      errors++; $display("FAIL no_stale_byte: got out=%h done=%b want 00/0", out32, done32);
    end
  endtask

  task automatic test_half;
    logic [2:0]  op [5];
    logic [15:0] a  [5];
    logic [15:0] b  [5];
    logic [15:0] r  [5];
    bit          hs [5];
    logic [31:0] got;
    int lat, nd, exp_lat;
    bit saw2, tail, bin;
    op = '{3'd1, 3'd0, 3'd2, 3'd1, 3'd4};
    a  = '{16'h3C00, 16'hBC00, 16'h7E00, 16'h7C01, 16'hC000};
    b  = '{16'h4000, 16'h3C00, 16'h3C00, 16'h0000, 16'h0000};
    r  = '{16'h4000, 16'hBC00, 16'h0008, 16'h7E00, 16'h4000};
    hs = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 5; i++) begin
      bin     = (op[i] != 3'd4);
      exp_lat = bin ? 6 : 4;
      xact(1'b1, op[i], {16'h0, a[i]}, {16'h0, b[i]}, hs[i], 1'b0, got, lat, nd, saw2, tail);
      vectors++;
      if (got[15:0] !== r[i]) begin
        errors++; $display("FAIL half%0d_result: got %h want %h", i, got[15:0], r[i]);
      end
      vectors++;
      if (lat != exp_lat) begin
        errors++; $display("FAIL half%0d_latency: got %0d want %0d", i, lat, exp_lat);
      end
      vectors++;
      if (nd != 2) begin
        errors++; $display("FAIL half%0d_done_cycles: got %0d want 2", i, nd);
      end
      vectors++;
      if (!tail) begin
        errors++; $display("FAIL half%0d_idle_after: got st=%0d out=%h done=%b want 0/00/0", i, st16, out16, done16);
      end
    end
  endtask

  initial begin
    test_reset;
    test_vectors;
    test_reset_mid_load;
    test_reset_mid_output;
    test_half;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/fp_serial_minmax.md
FP_SERIAL_MINMAX -- requirements
Module: fp_serial_minmax

Interface
REQ-001 SHALL have parameter EXP_W, default 8, exponent field width.
REQ-002 SHALL have parameter MAN_W, default 23, mantissa field width; W = 1+EXP_W+MAN_W SHALL be a multiple of 8; NB = W/8.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port in  input  8  operand byte, LSB-first.
REQ-006 SHALL have port opcode  input  3  operation select, sampled with start.
REQ-007 SHALL have port start  input  1  transaction request.
REQ-008 SHALL have port out  output  8  result byte, LSB-first.
REQ-009 SHALL have port done  output  1  high while a result byte is valid on out.
REQ-010 SHALL have port state_out  output  4  current FSM state code.

Function
REQ-011 SHALL implement FSM states and state_out codes: IDLE=0, LOAD_A=1, LOAD_B=2, EXEC=3, OUTPUT=4; no other codes appear.
REQ-012 In IDLE, an edge with start=1 SHALL latch opcode and go to LOAD_A; start=0 stays in IDLE.
REQ-013 start SHALL be ignored in every state except IDLE.
REQ-014 LOAD_A SHALL capture in on NB consecutive edges into operand A byte 0..NB-1 (LSB first), then go to LOAD_B (binary ops) or EXEC (unary ops NEG, ABS).
REQ-015 LOAD_B SHALL capture NB bytes into operand B likewise, then go to EXEC.
REQ-016 EXEC SHALL last exactly one cycle, register the W-bit result, then go to OUTPUT.
REQ-017 OUTPUT SHALL last exactly NB cycles, driving result byte k on out in the k-th cycle with done=1; then return to IDLE.
REQ-018 Outside OUTPUT, out SHALL be 8'h00 and done SHALL be 0.
REQ-019 Binary latency: start edge to first done cycle = 2*NB+2 edges; unary: NB+2 edges.
REQ-020 Opcodes: 000 MIN, 001 MAX, 010 CMP, 011 NEG, 100 ABS; 101-111 reserved, treated as binary, result all zeros.
REQ-021 MIN/MAX SHALL order -0 < +0 and compare finite/infinite values numerically per IEEE 754 sign-magnitude.
REQ-022 MIN/MAX with either operand NaN (exp all ones, mantissa nonzero) SHALL return canonical qNaN: sign 0, exp all ones, mantissa MSB 1, rest 0.
REQ-023 CMP SHALL return W-bit value with bits[3:0] = {unordered, gt, eq, lt} for A vs B, upper bits 0; +0 and -0 compare equal; any NaN gives 4'b1000.
REQ-024 NEG SHALL invert the sign bit only; ABS SHALL clear the sign bit only; NaN payloads passed unchanged.
REQ-025 Byte counter SHALL wrap to 0 on every state change; no byte lost or duplicated at LOAD_A->LOAD_B boundary.

Reset
REQ-026 rst_n=0 at an edge SHALL force state IDLE, out=0, done=0, state_out=0, counter=0, from any state including mid-LOAD or mid-OUTPUT.
REQ-027 Operand and result registers need no reset; no stale byte SHALL appear on out after reset.
REQ-028 First edge with rst_n=1 and start=1 SHALL begin a new transaction normally.

Verification
REQ-029 FP32 MAX: A=0x3F800000, B=0xC0000000 -> out bytes 00,00,80,3F, done high 4 cycles starting 10 edges after start.
REQ-030 FP32 MIN: A=0x00000000, B=0x80000000 -> 0x80000000; CMP same operands -> 0x00000002.
REQ-031 FP32 CMP: A=0x7FC00001, B=0x3F800000 -> 0x00000008; MAX same -> 0x7FC00000.
REQ-032 FP32 NEG: A=0x3F800000, no B bytes -> 0xBF800000, done 6 edges after start; state_out never 2.
REQ-033 Reset asserted during LOAD_B byte 2 -> next cycle state_out=0, out=0, done=0; following MAX(0x40000000,0x3F800000) -> 0x40000000.
REQ-034 EXP_W=5, MAN_W=10: MAX(0x3C00,0x4000) -> bytes 00,40; ABS(0xC000) -> 0x4000; start pulses during OUTPUT ignored.
